// File: rtl/uart_pkg.sv
// Shared UART timing constants and the command sequencer state encoding.
package uart_pkg;
   localparam int BAUD_DIV  = 5208;
   localparam int BYTE_CLKS = 10 * BAUD_DIV;
   localparam int TO_W      = 17;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      HOLD    = 2'b10
   } seq_state_e;
endpackage

// File: rtl/uart_to_timer.sv
// Inter-byte timeout counter: synchronous clear wins over enable; tc_o flags the last allowed clock.
module uart_to_timer
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 2 * BYTE_CLKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [TO_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + TO_W'(1);
      end
   end

   assign tc_o = (cnt_q == TO_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles CMD_BYTES received bytes (first byte = MSB) into a command word held under a ready/clear
// handshake; a gap longer than TIMEOUT_CLKS between bytes drops the partial frame and logs an error.
module uart_cmd_sequencer
   import uart_pkg::*;
#(
   parameter int CMD_BYTES    = 2,
   parameter int TIMEOUT_CLKS = 2 * BYTE_CLKS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_rdy,
   input  logic [7:0]             rx_data,
   output logic                   clr_rx_rdy,
   output logic [8*CMD_BYTES-1:0] cmd,
   output logic                   cmd_rdy,
   input  logic                   clr_cmd_rdy,
   output logic                   frame_err,
   output logic [7:0]             err_cnt
);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   seq_state_e             state_q;
   logic [8*CMD_BYTES-1:0] cmd_q;
   logic [8*CMD_BYTES-1:0] cmd_d;
   logic                   cmd_rdy_q;
   logic                   frame_err_q;
   logic [7:0]             err_cnt_q;
   logic [2:0]             byte_cnt_q;
   logic                   capture;
   logic                   last_byte;
   logic                   tc;
   logic                   timeout;

   // rst_n gates the ack so a receiver holding rx_rdy during reset is not cleared.
   assign capture   = rst_n & rx_rdy & ((state_q == IDLE) | (state_q == COLLECT));
   assign last_byte = (byte_cnt_q == 3'(CMD_BYTES - 1));
   assign timeout   = (state_q == COLLECT) & tc & ~capture;

   generate
      if (CMD_BYTES == 1) begin : g_one
         assign cmd_d = rx_data;
      end else begin : g_multi
         assign cmd_d = {cmd_q[8*CMD_BYTES-9:0], rx_data};
      end
   endgenerate

   uart_to_timer #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr_i(capture | (state_q != COLLECT) | tc),
      .en_i (state_q == COLLECT),
      .tc_o (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         cmd_rdy_q   <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= 8'd0;
         byte_cnt_q  <= 3'd0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE, COLLECT: begin
               if (capture) begin
                  cmd_q      <= cmd_d;
                  byte_cnt_q <= byte_cnt_q + 3'd1;
                  if (last_byte) begin
                     state_q   <= HOLD;
                     cmd_rdy_q <= 1'b1;
                  end else begin
                     state_q <= COLLECT;
                  end
               end else if (timeout) begin
                  state_q     <= IDLE;
                  byte_cnt_q  <= 3'd0;
                  frame_err_q <= 1'b1;
                  err_cnt_q   <= sat_inc8(err_cnt_q);
               end
            end
            HOLD: begin
               if (clr_cmd_rdy) begin
                  state_q    <= IDLE;
                  cmd_rdy_q  <= 1'b0;
                  byte_cnt_q <= 3'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_rx_rdy = capture;
   assign cmd        = cmd_q;
   assign cmd_rdy    = cmd_rdy_q;
   assign frame_err  = frame_err_q;
   assign err_cnt    = err_cnt_q;

endmodule
